// File: rtl/oled_pkg.sv
// Shared constants for the OLED SPI receiver: opcodes, panel geometry, decoder/addressing encodings.
// Optional build macro OLED_RX_PAGE_MODE_EN is consumed by oled_spi_rx.sv.
package oled_pkg;

   localparam int OLED_COLS     = 128;
   localparam int OLED_PAGES    = 8;
   localparam int OLED_FB_DEPTH = 1024;

   localparam logic [7:0] OP_DISP_OFF    = 8'hAE;
   localparam logic [7:0] OP_DISP_ON     = 8'hAF;
   localparam logic [7:0] OP_ENTIRE_OFF  = 8'hA4;
   localparam logic [7:0] OP_ENTIRE_ON   = 8'hA5;
   localparam logic [7:0] OP_NORMAL      = 8'hA6;
   localparam logic [7:0] OP_INVERT      = 8'hA7;
   localparam logic [7:0] OP_SEG_NORM    = 8'hA0;
   localparam logic [7:0] OP_SEG_REMAP   = 8'hA1;
   localparam logic [7:0] OP_COM_NORM    = 8'hC0;
   localparam logic [7:0] OP_COM_REMAP   = 8'hC8;
   localparam logic [7:0] OP_CONTRAST    = 8'h81;
   localparam logic [7:0] OP_ADDR_MODE   = 8'h20;
   localparam logic [7:0] OP_COL_ADDR    = 8'h21;
   localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;
   localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
   localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
   localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
   localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
   localparam logic [7:0] OP_VCOMH       = 8'hDB;
   localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;

   typedef enum logic [1:0] {AM_HORZ = 2'b00, AM_VERT = 2'b01, AM_PAGE = 2'b10} addr_mode_e;
   typedef enum logic [1:0] {ST_OP, ST_ARG1, ST_ARG2} dec_state_e;

   function automatic logic takes_arg(input logic [7:0] op);
      return (op == OP_CONTRAST)  || (op == OP_ADDR_MODE)   || (op == OP_COL_ADDR) ||
             (op == OP_PAGE_ADDR) || (op == OP_MUX_RATIO)   || (op == OP_DISP_OFFSET) ||
             (op == OP_CLK_DIV)   || (op == OP_PRECHARGE)   || (op == OP_VCOMH) ||
             (op == OP_CHARGE_PUMP);
   endfunction

endpackage

// File: rtl/oled_spi_rx_byte.sv
// spi_byte_rx: synchronises the SPI pins, detects sclk rising edges and assembles MSB-first bytes.
// Also yields the combined soft reset (rst_n or synchronised panel reset).
module spi_byte_rx
   import oled_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk_i,
   input  logic       sdin_i,
   input  logic       cs_i,
   input  logic       dc_i,
   input  logic       reset_n_i,
   output logic       srst_o,
   output logic       byte_valid_o,
   output logic [7:0] byte_o,
   output logic       dc_o,
   output logic       byte_err_o
);

   logic [4:0] raw, syn;
   assign raw = {reset_n_i, dc_i, cs_i, sdin_i, sclk_i};

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign syn = raw;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0][4:0] sync_q;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               sync_q <= '1;
            end else begin
               sync_q[0] <= raw;
               for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
         end
         assign syn = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   logic       sclk_prev_q, cs_prev_q;
   logic [2:0] cnt_q, cnt_d;
   logic [6:0] shift_q, shift_d;
   logic [7:0] byte_q, byte_d;
   logic       dc_q, dc_d, valid_q, valid_d, err_q, err_d;
   logic       sclk_rise, cs_rise, take;

   assign srst_o = ~rst_n | ~syn[4];

   // An edge coincident with cs rising still counts, so a byte finishing as cs lifts is not an error.
   always_comb begin
      sclk_rise = syn[0] & ~sclk_prev_q;
      cs_rise   = syn[2] & ~cs_prev_q;
      take      = sclk_rise & (~syn[2] | cs_rise);
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      byte_d    = byte_q;
      dc_d      = dc_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      if (take) begin
         shift_d = {shift_q[5:0], syn[1]};
         if (cnt_q == 3'd7) begin
            byte_d  = {shift_q, syn[1]};
            dc_d    = syn[3];
            valid_d = 1'b1;
            cnt_d   = 3'd0;
         end else if (cs_rise) begin
            err_d = 1'b1;
            cnt_d = 3'd0;
         end else begin
            cnt_d = cnt_q + 3'd1;
         end
      end else if (cs_rise && cnt_q != 3'd0) begin
         err_d = 1'b1;
         cnt_d = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      sclk_prev_q <= syn[0];
      cs_prev_q   <= syn[2];
      if (srst_o) begin
         cnt_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         dc_q    <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         dc_q    <= dc_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign byte_valid_o = valid_q;
   assign byte_o       = byte_q;
   assign dc_o         = dc_q;
   assign byte_err_o   = err_q;

endmodule

// File: rtl/oled_spi_rx.sv
// OLED panel SPI sink: decodes commands into panel state and writes data bytes to a framebuffer.
// Build macro OLED_RX_PAGE_MODE_EN adds vertical/page addressing and the B0-B7/00-1F opcodes.
module oled_spi_rx
   import oled_pkg::*;
#(
   parameter int         SYNC_STAGES  = 2,
   parameter logic [7:0] CONTRAST_RST = 8'h7F
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_sclk,
   input  logic       spi_sdin,
   input  logic       spi_cs,
   input  logic       spi_dc,
   input  logic       spi_reset,
   output logic       fb_we,
   output logic [9:0] fb_addr,
   output logic [7:0] fb_wdata,
   output logic       display_on,
   output logic [7:0] contrast,
   output logic       invert,
   output logic       entire_on,
   output logic       seg_remap,
   output logic       com_remap,
   output logic [5:0] start_line,
   output logic       charge_pump,
   output logic       frame_done,
   output logic       byte_err
);

   logic       srst, rx_valid, rx_dc;
   logic [7:0] b;

   spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
      .clk(clk), .rst_n(rst_n), .sclk_i(spi_sclk), .sdin_i(spi_sdin), .cs_i(spi_cs),
      .dc_i(spi_dc), .reset_n_i(spi_reset), .srst_o(srst), .byte_valid_o(rx_valid),
      .byte_o(b), .dc_o(rx_dc), .byte_err_o(byte_err)
   );

   dec_state_e state_q, state_d;
   logic [7:0] pend_q, pend_d, contrast_q, contrast_d, wdata_q, wdata_d;
   logic [6:0] arg1_q, arg1_d, col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
   logic [2:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
   logic [5:0] start_line_q, start_line_d;
   logic [9:0] addr_q, addr_d;
   logic disp_q, disp_d, inv_q, inv_d, ent_q, ent_d, seg_q, seg_d, com_q, com_d;
   logic cp_q, cp_d, we_q, we_d, fd_q, fd_d;
`ifdef OLED_RX_PAGE_MODE_EN
   addr_mode_e mode_q, mode_d;
`endif

   always_comb begin
      state_d = state_q;  pend_d = pend_q;  arg1_d = arg1_q;
      contrast_d = contrast_q;  start_line_d = start_line_q;
      disp_d = disp_q;  inv_d = inv_q;  ent_d = ent_q;  seg_d = seg_q;  com_d = com_q;  cp_d = cp_q;
      col_d = col_q;  col_start_d = col_start_q;  col_end_d = col_end_q;
      page_d = page_q;  page_start_d = page_start_q;  page_end_d = page_end_q;
      addr_d = addr_q;  wdata_d = wdata_q;  we_d = 1'b0;  fd_d = 1'b0;
`ifdef OLED_RX_PAGE_MODE_EN
      mode_d = mode_q;
`endif
      if (rx_valid && rx_dc) begin
         // Data aborts any half-received command and always goes to the framebuffer.
         state_d = ST_OP;
         we_d    = 1'b1;
         addr_d  = {page_q, col_q};
         wdata_d = b;
`ifdef OLED_RX_PAGE_MODE_EN
         if (mode_q == AM_VERT) begin
            if (page_q == page_end_q) begin
               page_d = page_start_q;
               if (col_q == col_end_q) begin
                  col_d = col_start_q;
                  fd_d  = 1'b1;
               end else begin
                  col_d = col_q + 7'd1;
               end
            end else begin
               page_d = page_q + 3'd1;
            end
         end else if (mode_q == AM_PAGE) begin
            col_d = col_q + 7'd1;
         end else
`endif
         begin
            if (col_q == col_end_q) begin
               col_d = col_start_q;
               if (page_q == page_end_q) begin
                  page_d = page_start_q;
                  fd_d   = 1'b1;
               end else begin
                  page_d = page_q + 3'd1;
               end
            end else begin
               col_d = col_q + 7'd1;
            end
         end
      end else if (rx_valid) begin
         case (state_q)
            ST_OP: begin
               if (b == OP_DISP_OFF || b == OP_DISP_ON)           disp_d = b[0];
               else if (b == OP_ENTIRE_OFF || b == OP_ENTIRE_ON)  ent_d  = b[0];
               else if (b == OP_NORMAL || b == OP_INVERT)         inv_d  = b[0];
               else if (b == OP_SEG_NORM || b == OP_SEG_REMAP)    seg_d  = b[0];
               else if (b == OP_COM_NORM)                         com_d  = 1'b0;
               else if (b == OP_COM_REMAP)                        com_d  = 1'b1;
               else if (b[7:6] == 2'b01)                          start_line_d = b[5:0];
               else if (takes_arg(b)) begin
                  pend_d  = b;
                  state_d = ST_ARG1;
               end
`ifdef OLED_RX_PAGE_MODE_EN
               else if (b[7:3] == 5'b10110) page_d = b[2:0];
               else if (b[7:4] == 4'h0)     col_d  = {col_q[6:4], b[3:0]};
               else if (b[7:4] == 4'h1)     col_d  = {b[2:0], col_q[3:0]};
`endif
            end
            ST_ARG1: begin
               state_d = ST_OP;
               case (pend_q)
                  OP_CONTRAST:    contrast_d = b;
                  OP_CHARGE_PUMP: cp_d = b[2];
                  OP_COL_ADDR, OP_PAGE_ADDR: begin
                     arg1_d  = b[6:0];
                     state_d = ST_ARG2;
                  end
`ifdef OLED_RX_PAGE_MODE_EN
                  OP_ADDR_MODE: mode_d = (b[1:0] == 2'b00) ? AM_HORZ :
                                         (b[1:0] == 2'b01) ? AM_VERT : AM_PAGE;
`endif
                  default: ;
               endcase
            end
            ST_ARG2: begin
               state_d = ST_OP;
               if (pend_q == OP_COL_ADDR) begin
                  col_start_d = arg1_q;
                  col_end_d   = b[6:0];
                  col_d       = arg1_q;
               end else begin
                  page_start_d = arg1_q[2:0];
                  page_end_d   = b[2:0];
                  page_d       = arg1_q[2:0];
               end
            end
            default: state_d = ST_OP;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= ST_OP;  pend_q <= '0;  arg1_q <= '0;
         contrast_q <= CONTRAST_RST;  start_line_q <= '0;
         disp_q <= 1'b0;  inv_q <= 1'b0;  ent_q <= 1'b0;  seg_q <= 1'b0;  com_q <= 1'b0;  cp_q <= 1'b0;
         col_q <= '0;  col_start_q <= '0;  col_end_q <= 7'd127;
         page_q <= '0;  page_start_q <= '0;  page_end_q <= 3'd7;
         addr_q <= '0;  wdata_q <= '0;  we_q <= 1'b0;  fd_q <= 1'b0;
`ifdef OLED_RX_PAGE_MODE_EN
         mode_q <= AM_HORZ;
`endif
      end else begin
         state_q <= state_d;  pend_q <= pend_d;  arg1_q <= arg1_d;
         contrast_q <= contrast_d;  start_line_q <= start_line_d;
         disp_q <= disp_d;  inv_q <= inv_d;  ent_q <= ent_d;  seg_q <= seg_d;  com_q <= com_d;  cp_q <= cp_d;
         col_q <= col_d;  col_start_q <= col_start_d;  col_end_q <= col_end_d;
         page_q <= page_d;  page_start_q <= page_start_d;  page_end_q <= page_end_d;
         addr_q <= addr_d;  wdata_q <= wdata_d;  we_q <= we_d;  fd_q <= fd_d;
`ifdef OLED_RX_PAGE_MODE_EN
         mode_q <= mode_d;
`endif
      end
   end

   assign fb_we       = we_q;
   assign fb_addr     = addr_q;
   assign fb_wdata    = wdata_q;
   assign frame_done  = fd_q;
   assign display_on  = disp_q;
   assign contrast    = contrast_q;
   assign invert      = inv_q;
   assign entire_on   = ent_q;
   assign seg_remap   = seg_q;
   assign com_remap   = com_q;
   assign start_line  = start_line_q;
   assign charge_pump = cp_q;

endmodule
